// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker: streaming top-K spectral peak finder.
// Consumes one FFT magnitude per transfer with its bin index and keeps the
// NUM_PEAKS largest in-window bins in a magnitude-sorted register list.
// After frame end the list is drained slot 0..K-1 over an AXI-style stream.
// Optional feature: define FFT_PEAK_LOCAL_MAX_EN to accept only local maxima
// (adds a 2-sample delay line; drain then starts one cycle later).
//
// Handshake: a transfer happens on any rising clk edge where tvalid && tready
// are both high; the source holds data stable while tvalid && !tready.
module fft_peak_tracker #(
    parameter int MAG_W     = 32,
    parameter int IDX_W     = 10,
    parameter int FRAME_LEN = 1024,
    parameter int NUM_PEAKS = 2,
    parameter int MIN_BIN   = 1,
    parameter int MAX_BIN   = 511
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_mag_tvalid,
    output logic             s_mag_tready,
    input  logic [MAG_W-1:0] s_mag_tdata,
    input  logic [IDX_W-1:0] s_mag_tuser,
    input  logic             s_mag_tlast,
    output logic             m_pk_tvalid,
    input  logic             m_pk_tready,
    output logic [MAG_W-1:0] m_pk_tdata,
    output logic [IDX_W-1:0] m_pk_tidx,
    output logic             m_pk_tlast,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int PTR_W = (NUM_PEAKS > 1) ? $clog2(NUM_PEAKS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t           state;
    logic [MAG_W-1:0] list_mag [NUM_PEAKS];
    logic [IDX_W-1:0] list_idx [NUM_PEAKS];
    logic [MAG_W-1:0] nxt_mag  [NUM_PEAKS];
    logic [IDX_W-1:0] nxt_idx  [NUM_PEAKS];
    logic [MAG_W-1:0] sh_mag   [NUM_PEAKS];
    logic [IDX_W-1:0] sh_idx   [NUM_PEAKS];
    logic [NUM_PEAKS-1:0] gt;
    logic [NUM_PEAKS-1:0] above;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic             out_valid;
    logic             err_q;

    logic             in_xfer, out_xfer, at_len, frame_end, bad_len, last_slot, list_clr;
    logic [MAG_W-1:0] cand_mag;
    logic [IDX_W-1:0] cand_idx;
    logic             cand_en;

    function automatic logic in_window(input logic [IDX_W-1:0] idx);
        return (32'(idx) >= 32'(MIN_BIN)) && (32'(idx) <= 32'(MAX_BIN));
    endfunction

    assign s_mag_tready = (state != DRAIN);
    assign in_xfer      = s_mag_tvalid && s_mag_tready;
    assign out_xfer     = out_valid && m_pk_tready;
    assign at_len       = (count == CNT_W'(FRAME_LEN - 1));
    assign frame_end    = in_xfer && (s_mag_tlast || at_len);
    // Early tlast and missing tlast both show up as tlast disagreeing with the length.
    assign bad_len      = (s_mag_tlast != at_len);
    assign last_slot    = (rd_ptr == PTR_W'(NUM_PEAKS - 1));
    assign list_clr     = (state == DRAIN) && out_xfer && last_slot;

    assign m_pk_tvalid  = out_valid;
    assign m_pk_tdata   = out_valid ? list_mag[rd_ptr] : '0;
    assign m_pk_tidx    = out_valid ? list_idx[rd_ptr] : '0;
    assign m_pk_tlast   = out_valid && last_slot;
    assign frame_err    = err_q;

`ifdef FFT_PEAK_LOCAL_MAX_EN
    // d1 is the bin under evaluation, d0 its left neighbour; the incoming sample is the right one.
    logic [MAG_W-1:0] d1_mag, d0_mag, right_mag;
    logic [IDX_W-1:0] d1_idx;
    logic             d1_vld, flush;

    assign right_mag = flush ? '0 : s_mag_tdata;
    assign cand_mag  = d1_mag;
    assign cand_idx  = d1_idx;
    assign cand_en   = d1_vld && (in_xfer || flush) && (d1_mag > d0_mag) &&
                       (d1_mag >= right_mag) && in_window(d1_idx);
`else
    assign cand_mag  = s_mag_tdata;
    assign cand_idx  = s_mag_tuser;
    assign cand_en   = in_xfer && in_window(s_mag_tuser);
`endif

    // Sorted insert: the candidate lands at the first slot it strictly beats and
    // everything below shifts down. Empty slots hold 0, so zero magnitudes never enter.
    always_comb begin
        above[0]  = 1'b0;
        sh_mag[0] = '0;
        sh_idx[0] = '0;
        for (int i = 0; i < NUM_PEAKS; i++) gt[i] = (cand_mag > list_mag[i]);
        for (int i = 1; i < NUM_PEAKS; i++) begin
            above[i]  = gt[i-1];
            sh_mag[i] = list_mag[i-1];
            sh_idx[i] = list_idx[i-1];
        end
        for (int i = 0; i < NUM_PEAKS; i++) begin
            if (list_clr) begin
                nxt_mag[i] = '0;
                nxt_idx[i] = '0;
            end else if (cand_en && gt[i]) begin
                nxt_mag[i] = above[i] ? sh_mag[i] : cand_mag;
                nxt_idx[i] = above[i] ? sh_idx[i] : cand_idx;
            end else begin
                nxt_mag[i] = list_mag[i];
                nxt_idx[i] = list_idx[i];
            end
        end
    end

    // Control FSM, sample counter, peak list and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            err_q     <= 1'b0;
            for (int i = 0; i < NUM_PEAKS; i++) begin
                list_mag[i] <= '0;
                list_idx[i] <= '0;
            end
`ifdef FFT_PEAK_LOCAL_MAX_EN
            d1_mag <= '0;
            d0_mag <= '0;
            d1_idx <= '0;
            d1_vld <= 1'b0;
            flush  <= 1'b0;
`endif
        end else begin
            err_q <= 1'b0;
            for (int i = 0; i < NUM_PEAKS; i++) begin
                list_mag[i] <= nxt_mag[i];
                list_idx[i] <= nxt_idx[i];
            end
            case (state)
                IDLE, SCAN: begin
                    if (in_xfer) begin
                        state <= SCAN;
                        if (count < CNT_W'(FRAME_LEN)) count <= count + CNT_W'(1);
`ifdef FFT_PEAK_LOCAL_MAX_EN
                        d0_mag <= d1_mag;
                        d1_mag <= s_mag_tdata;
                        d1_idx <= s_mag_tuser;
                        d1_vld <= 1'b1;
`endif
                        if (frame_end) begin
                            state  <= DRAIN;
                            count  <= '0;
                            rd_ptr <= '0;
                            err_q  <= bad_len;
`ifdef FFT_PEAK_LOCAL_MAX_EN
                            flush  <= 1'b1;
`else
                            out_valid <= 1'b1;
`endif
                        end
                    end
                end
                DRAIN: begin
`ifdef FFT_PEAK_LOCAL_MAX_EN
                    // Last bin was evaluated this cycle against a zero right neighbour.
                    if (flush) begin
                        flush     <= 1'b0;
                        out_valid <= 1'b1;
                        d1_mag    <= '0;
                        d0_mag    <= '0;
                        d1_idx    <= '0;
                        d1_vld    <= 1'b0;
                    end
`endif
                    if (out_xfer) begin
                        if (last_slot) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                            rd_ptr    <= '0;
                        end else begin
                            rd_ptr <= rd_ptr + PTR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
